// File: rtl/mem_arbiter.sv
// N-port pipelined memory arbiter.
//
// Picks one requester per cycle (round-robin or fixed priority) and issues
// its command to a single fixed-latency memory. Reads are tagged with the
// issuing port and returned in order.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req/i_we            per-port request and write enable
//   i_addr/i_wdata        flattened per-port address / write data
//   o_gnt                 one-hot grant pulse (command accepted)
//   o_rvalid/o_rdata      one-hot read-return pulse and its data
//   i_mem_ready           memory accepts a command this cycle
//   mem_en/mem_we         command valid / write strobe to memory
//   mem_addr/mem_wdata    command address / write data
//   i_mem_rdata           read data, MEM_LATENCY cycles after mem_en
module mem_arbiter #(
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned ARB_MODE    = 0
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_PORTS-1:0]        i_req,
  input  logic [NUM_PORTS-1:0]        i_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] i_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] i_wdata,
  output logic [NUM_PORTS-1:0]        o_gnt,
  output logic [NUM_PORTS-1:0]        o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  input  logic                        i_mem_ready,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           i_mem_rdata
);

  localparam int unsigned IdxW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef logic [IdxW-1:0] idx_t;

  // One stage of the read-return tag pipeline.
  typedef struct packed {
    logic vld;
    idx_t port;
  } tag_t;

  logic [ADDR_W-1:0] addr_arr  [NUM_PORTS];
  logic [DATA_W-1:0] wdata_arr [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign addr_arr[p]  = i_addr[p*ADDR_W +: ADDR_W];
    assign wdata_arr[p] = i_wdata[p*DATA_W +: DATA_W];
  end

  idx_t                 ptr_q, ptr_d;
  idx_t                 cmd_port_q, cmd_port_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [NUM_PORTS-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 mem_en_q, mem_en_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  tag_t                 tag_q [MEM_LATENCY];
  tag_t                 tag_d [MEM_LATENCY];

  logic win_vld;
  idx_t win_idx;
  idx_t cand;

  // Winner selection. Loops run from lowest to highest priority so the last
  // hit (highest priority) is what sticks.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (i_mem_ready) begin
      if (ARB_MODE == 1) begin
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
          if (i_req[idx_t'(i)]) begin
            win_vld = 1'b1;
            win_idx = idx_t'(i);
          end
        end
      end else begin
        for (int i = int'(NUM_PORTS); i >= 1; i--) begin
          cand = idx_t'((32'(ptr_q) + 32'(i)) % NUM_PORTS);
          if (i_req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
          end
        end
      end
    end
  end

  always_comb begin
    gnt_d       = '0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cmd_port_d  = cmd_port_q;
    ptr_d       = ptr_q;

    if (win_vld) begin
      gnt_d[win_idx] = 1'b1;
      mem_en_d       = 1'b1;
      mem_we_d       = i_we[win_idx];
      mem_addr_d     = addr_arr[win_idx];
      mem_wdata_d    = wdata_arr[win_idx];
      cmd_port_d     = win_idx;
      if (ARB_MODE == 0) begin
        ptr_d = win_idx;
      end
    end

    // The command on the bus this cycle enters the tag pipeline; it emerges
    // in the cycle its read data is on i_mem_rdata.
    tag_d[0].vld  = mem_en_q & ~mem_we_q;
    tag_d[0].port = cmd_port_q;
    for (int i = 1; i < int'(MEM_LATENCY); i++) begin
      tag_d[i] = tag_q[i-1];
    end

    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (tag_q[MEM_LATENCY-1].vld) begin
      rvalid_d[tag_q[MEM_LATENCY-1].port] = 1'b1;
      rdata_d                             = i_mem_rdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q       <= idx_t'(NUM_PORTS - 1);
      cmd_port_q  <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      cmd_port_q  <= cmd_port_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      for (int i = 0; i < int'(MEM_LATENCY); i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign o_gnt     = gnt_q;
  assign o_rvalid  = rvalid_q;
  assign o_rdata   = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (round-robin, latency 2; fixed
// priority, latency 3) share reset/ready and receive the same transactions.
module tb_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NI   = 2;
  localparam int HMAX = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ready;
  logic [N-1:0]    req    [NI];
  logic [N-1:0]    we     [NI];
  logic [N*AW-1:0] addr_f [NI];
  logic [N*DW-1:0] wdat_f [NI];
  logic [N-1:0]    gnt    [NI];
  logic [N-1:0]    rvalid [NI];
  logic [DW-1:0]   rdata  [NI];
  logic            men    [NI];
  logic            mwe    [NI];
  logic [AW-1:0]   maddr  [NI];
  logic [DW-1:0]   mwdata [NI];
  logic [DW-1:0]   mrdata [NI];

  mem_arbiter #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(2), .ARB_MODE(0)
  ) u_dut_rr (
    .i_clk(clk), .i_rst(rst), .i_req(req[0]), .i_we(we[0]), .i_addr(addr_f[0]),
    .i_wdata(wdat_f[0]), .o_gnt(gnt[0]), .o_rvalid(rvalid[0]), .o_rdata(rdata[0]),
    .i_mem_ready(ready), .mem_en(men[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]),
    .mem_wdata(mwdata[0]), .i_mem_rdata(mrdata[0])
  );

  mem_arbiter #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .ARB_MODE(1)
  ) u_dut_fp (
    .i_clk(clk), .i_rst(rst), .i_req(req[1]), .i_we(we[1]), .i_addr(addr_f[1]),
    .i_wdata(wdat_f[1]), .o_gnt(gnt[1]), .o_rvalid(rvalid[1]), .o_rdata(rdata[1]),
    .i_mem_ready(ready), .mem_en(men[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]),
    .mem_wdata(mwdata[1]), .i_mem_rdata(mrdata[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // Memory contents: a few fixed words, everything else derived from the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h40:  return 32'hDEAD_BEEF;
      32'h00:  return 32'h0000_0011;
      32'h04:  return 32'h0000_0022;
      default: return a * 32'd3 + 32'h1000;
    endcase
  endfunction

  // Pending requester transactions; the front entry per (instance, port) is driven.
  typedef struct {
    int          k;
    int          p;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;
  txn_t txq[$];

  // Expected read returns.
  typedef struct {
    int          k;
    int          due;
    int          p;
    logic [31:0] data;
  } ret_t;
  ret_t retq[$];

  int          m_ptr   [NI];
  logic [N-1:0] e_gnt  [NI];
  logic [N-1:0] e_rv   [NI];
  logic         e_en   [NI];
  logic         e_we   [NI];
  logic [31:0]  e_addr [NI];
  logic [31:0]  e_wdata[NI];
  logic [31:0]  e_rdata[NI];

  logic         hist_rd   [NI][HMAX];
  logic [31:0]  hist_addr [NI][HMAX];

  int cyc;
  int n_checks;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic push_txn(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] d);
    txn_t t;
    for (int k = 0; k < NI; k++) begin
      t.k = k; t.p = p; t.w = w; t.a = a; t.d = d;
      txq.push_back(t);
    end
  endtask

  task automatic drive_reqs();
    for (int k = 0; k < NI; k++) begin
      req[k] = '0; we[k] = '0; addr_f[k] = '0; wdat_f[k] = '0;
      for (int p = 0; p < int'(N); p++) begin
        for (int i = 0; i < txq.size(); i++) begin
          if (txq[i].k == k && txq[i].p == p) begin
            req[k][p]            = 1'b1;
            we[k][p]             = txq[i].w;
            addr_f[k][p*AW +: AW] = txq[i].a;
            wdat_f[k][p*DW +: DW] = txq[i].d;
            break;
          end
        end
      end
    end
  endtask

  // Requesters drop the granted transaction in the cycle the grant is seen.
  task automatic pop_granted();
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < int'(N); p++) begin
        if (gnt[k][p] === 1'b1) begin
          for (int i = 0; i < txq.size(); i++) begin
            if (txq[i].k == k && txq[i].p == p) begin
              txq.delete(i);
              break;
            end
          end
        end
      end
    end
  endtask

  // From the inputs of the current cycle, work out what every output must be
  // in the next cycle.
  task automatic model_advance();
    int   nxt;
    int   w;
    int   c;
    ret_t r;
    nxt = cyc + 1;
    for (int k = 0; k < NI; k++) begin
      w = -1;
      if (rst) begin
        e_gnt[k] = '0; e_en[k] = 1'b0; e_we[k] = 1'b0; e_addr[k] = '0;
        e_wdata[k] = '0; e_rv[k] = '0; e_rdata[k] = '0;
        m_ptr[k] = N - 1;
        for (int i = retq.size() - 1; i >= 0; i--) begin
          if (retq[i].k == k) retq.delete(i);
        end
      end else begin
        if (ready && req[k] != '0) begin
          if (k == 1) begin
            for (int p = 0; p < int'(N) && w < 0; p++) if (req[k][p]) w = p;
          end else begin
            for (int i = 1; i <= int'(N) && w < 0; i++) begin
              c = (m_ptr[k] + i) % N;
              if (req[k][c]) w = c;
            end
          end
        end
        if (w >= 0) begin
          e_gnt[k]   = N'(1) << w;
          e_en[k]    = 1'b1;
          e_we[k]    = we[k][w];
          e_addr[k]  = addr_f[k][w*AW +: AW];
          e_wdata[k] = wdat_f[k][w*DW +: DW];
          if (k == 0) m_ptr[k] = w;
          if (!we[k][w]) begin
            r.k = k; r.due = nxt + lat_of(k) + 1; r.p = w; r.data = mem_val(e_addr[k]);
            retq.push_back(r);
          end
        end else begin
          e_gnt[k] = '0; e_en[k] = 1'b0; e_we[k] = 1'b0;
        end
        e_rv[k] = '0;
        for (int i = 0; i < retq.size(); i++) begin
          if (retq[i].k == k && retq[i].due == nxt) begin
            e_rv[k]    = N'(1) << retq[i].p;
            e_rdata[k] = retq[i].data;
            retq.delete(i);
            break;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("k%0d_gnt", k),    32'(gnt[k]),    32'(e_gnt[k]));
      chk($sformatf("k%0d_mem_en", k), 32'(men[k]),    32'(e_en[k]));
      chk($sformatf("k%0d_mem_we", k), 32'(mwe[k]),    32'(e_we[k]));
      chk($sformatf("k%0d_addr", k),   maddr[k],       e_addr[k]);
      chk($sformatf("k%0d_wdata", k),  mwdata[k],      e_wdata[k]);
      chk($sformatf("k%0d_rvalid", k), 32'(rvalid[k]), 32'(e_rv[k]));
      chk($sformatf("k%0d_rdata", k),  rdata[k],       e_rdata[k]);
    end
  endtask

  task automatic step();
    drive_reqs();
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    for (int k = 0; k < NI; k++) begin
      if (cyc < HMAX) begin
        hist_rd[k][cyc]   = men[k] & ~mwe[k];
        hist_addr[k][cyc] = maddr[k];
      end
      if (cyc >= lat_of(k) && cyc - lat_of(k) < HMAX && hist_rd[k][cyc-lat_of(k)] === 1'b1)
        mrdata[k] = mem_val(hist_addr[k][cyc-lat_of(k)]);
      else
        mrdata[k] = 32'hBAD0_0000 + 32'(cyc);
    end
    pop_granted();
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (txq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    chk("drain_done", 32'(txq.size()), 32'd0);
    repeat (6) step();
  endtask

  logic [N-1:0] rv_seen;

  initial begin
    cyc = 0; n_checks = 0; n_err = 0;
    rst = 1'b1; ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      mrdata[k] = '0;
      for (int i = 0; i < HMAX; i++) begin
        hist_rd[k][i] = 1'b0; hist_addr[k][i] = '0;
      end
    end

    // Reset / idle
    step(); step();
    rst = 1'b0;
    repeat (10) step();
    chk("idle_gnt", 32'(gnt[0]), 32'd0);
    chk("idle_mem_en", 32'(men[1]), 32'd0);

    // All ports request continuously: RR rotates, FP stays on port 0
    for (int p = 0; p < int'(N); p++)
      for (int i = 0; i < 8; i++) push_txn(p, 1'b0, 32'h100 + 32'(p*64 + i*4), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_seq%0d", i), 32'(gnt[0]), 32'(N'(1) << (i % 4)));
      chk($sformatf("fp_seq%0d", i), 32'(gnt[1]), 32'h1);
    end
    drain();

    // Single read, port 1, addr 0x40
    push_txn(1, 1'b0, 32'h40, 32'h0);
    step();
    chk("rd1_gnt", 32'(gnt[0]), 32'b0010);
    chk("rd1_addr", maddr[0], 32'h40);
    step(); step(); step();
    chk("rd1_rvalid", 32'(rvalid[0]), 32'b0010);
    chk("rd1_rdata", rdata[0], 32'hDEAD_BEEF);
    chk("rd1_fp_early", 32'(rvalid[1]), 32'h0);
    step();
    chk("rd1_fp_rvalid", 32'(rvalid[1]), 32'b0010);
    chk("rd1_fp_rdata", rdata[1], 32'hDEAD_BEEF);
    drain();

    // Backpressure on a port 0 write
    ready = 1'b0;
    push_txn(0, 1'b1, 32'h10, 32'h55);
    repeat (3) begin
      step();
      chk("bp_no_gnt", 32'(gnt[0]), 32'h0);
      chk("bp_no_en", 32'(men[0]), 32'h0);
    end
    ready = 1'b1;
    step();
    chk("bp_gnt", 32'(gnt[0]), 32'h1);
    chk("bp_we", 32'(mwe[0]), 32'h1);
    chk("bp_addr", maddr[0], 32'h10);
    chk("bp_wdata", mwdata[0], 32'h55);
    drain();

    // Back-to-back reads on ports 0 and 1
    push_txn(0, 1'b0, 32'h0, 32'h0);
    step();
    chk("il_gnt0", 32'(gnt[0]), 32'h1);
    push_txn(1, 1'b0, 32'h4, 32'h0);
    step();
    chk("il_gnt1", 32'(gnt[0]), 32'h2);
    step(); step();
    chk("il_rv0", 32'(rvalid[0]), 32'h1);
    chk("il_rd0", rdata[0], 32'h11);
    step();
    chk("il_rv1", 32'(rvalid[0]), 32'h2);
    chk("il_rd1", rdata[0], 32'h22);
    drain();

    // Same, with a port 2 write between the reads
    push_txn(0, 1'b0, 32'h0, 32'h0);
    step();
    push_txn(2, 1'b1, 32'h8, 32'h77);
    step();
    chk("ilw_gnt2", 32'(gnt[0]), 32'h4);
    push_txn(1, 1'b0, 32'h4, 32'h0);
    step(); step();
    chk("ilw_rv0", 32'(rvalid[0]), 32'h1);
    chk("ilw_rd0", rdata[0], 32'h11);
    step();
    chk("ilw_gap", 32'(rvalid[0]), 32'h0);
    chk("ilw_hold", rdata[0], 32'h11);
    step();
    chk("ilw_rv1", 32'(rvalid[0]), 32'h2);
    chk("ilw_rd1", rdata[0], 32'h22);
    drain();

    // Reset one cycle after mem_en of an in-flight read
    push_txn(1, 1'b0, 32'h40, 32'h0);
    step();
    chk("mid_en", 32'(men[1]), 32'h1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_en", 32'(men[0]), 32'h0);
    rv_seen = '0;
    repeat (8) begin
      step();
      rv_seen = rv_seen | rvalid[0] | rvalid[1];
    end
    chk("mid_no_rvalid", 32'(rv_seen), 32'h0);
    for (int p = 0; p < int'(N); p++) push_txn(p, 1'b0, 32'h200 + 32'(p*4), 32'h0);
    step();
    chk("mid_rr_restart", 32'(gnt[0]), 32'h1);
    chk("mid_fp_first", 32'(gnt[1]), 32'h1);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- N-port pipelined memory arbiter between pipeline stages (fetch, mem-access, future DMA/debug ports) and a single fixed-latency memory.
- Successor to the combinational two-port memory controller: parametrised in port count, address/data width and read latency.
- Adds round-robin or fixed-priority arbitration, request/grant handshake, backpressure, and tagged in-order read return.
- Sits between stage_1/stage_4 (and further requesters) and the memory array.

Parameters:
NUM_PORTS, 2, number of requester ports (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LATENCY, 1, cycles from mem_en to valid i_mem_rdata (1..4)
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (port 0 highest)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req  in  NUM_PORTS  per-port request; held until granted
i_we  in  NUM_PORTS  per-port write enable (1 = write, 0 = read)
i_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port p at bits [p*ADDR_W +: ADDR_W]
i_wdata  in  NUM_PORTS*DATA_W  flattened write data
o_gnt  out  NUM_PORTS  one-hot, one-cycle grant pulse; request accepted this cycle
o_rvalid  out  NUM_PORTS  one-hot read-data-valid pulse
o_rdata  out  DATA_W  read data, qualified by o_rvalid
i_mem_ready  in  1  memory can accept a command this cycle
mem_en  out  1  command valid to memory
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  command address
mem_wdata  out  DATA_W  command write data
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LATENCY cycles after the read command

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset state: o_gnt = 0, o_rvalid = 0, o_rdata = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. Tag pipeline cleared. RR pointer = NUM_PORTS-1, so port 0 has first priority.
- Arbitration (combinational, registered outputs):
  - A winner is chosen each cycle in which i_mem_ready = 1 and any i_req is set.
  - Round-robin: search ports starting at pointer+1, wrapping modulo NUM_PORTS. Pointer updates to the winner on grant only.
  - Fixed priority: lowest-index requesting port wins. Pointer is unused.
- Grant timing:
  - At the clock edge after arbitration: o_gnt[winner] = 1 for exactly one cycle.
  - Same edge: mem_en = 1, and mem_we/mem_addr/mem_wdata take the winner's values.
  - If no grant, mem_en = 0 and mem_we = 0 next cycle; mem_addr/mem_wdata hold.
- Requester rule: the requester deasserts i_req, or presents a new request, in the cycle o_gnt is seen. Back-to-back grants to the same port are allowed: at most one per cycle, one command per cycle in total.
- Backpressure: i_mem_ready = 0 → no grant that cycle. Requests stay pending. In-flight reads continue unaffected.
- Read return:
  - A MEM_LATENCY-deep shift register carries {valid, port_id} for each issued read. Writes push valid = 0.
  - When the tag emerges, o_rvalid[port_id] = 1 and o_rdata = i_mem_rdata, both registered.
  - Total read latency: arbitration cycle → mem_en (+1) → o_rvalid at mem_en + MEM_LATENCY + 1.
  - Returns are in issue order. o_rdata holds its last value when o_rvalid = 0.
- Writes: completion is implied by o_gnt; no o_rvalid is generated.
- Simultaneous events:
  - A read return and a new grant in the same cycle are independent.
  - All ports requesting under RR are served in rotation; none is starved for more than NUM_PORTS-1 grants.
- Reset mid-operation: all in-flight tags dropped; no o_rvalid after reset; outputs go to reset values on the next edge.
- Width rules: port indexing uses $clog2(NUM_PORTS) bits, minimum 1. No arithmetic on data.

Test Plan:
- Reset/idle: assert i_rst 2 cycles, no requests → all outputs 0 for 10 cycles; mem_en never 1.
- Single read, port 1, addr 0x40, MEM_LATENCY = 2, memory returns 0xDEADBEEF → o_gnt = 2'b10 one cycle after req; mem_addr = 0x40; o_rvalid = 2'b10 with o_rdata = 0xDEADBEEF 3 cycles after the grant cycle.
- RR fairness: NUM_PORTS = 4, all i_req held high for 8 cycles → grant sequence 0,1,2,3,0,1,2,3; ARB_MODE = 1 with the same stimulus → port 0 granted every cycle.
- Backpressure: port 0 write addr 0x10 data 0x55, i_mem_ready = 0 for 3 cycles → no o_gnt and mem_en = 0 throughout; grant and mem_we = 1 with mem_wdata = 0x55 on the edge after i_mem_ready rises.
- Pipelined interleave: reads port 0 addr 0x0 and port 1 addr 0x4 on consecutive cycles, memory returns 0x11 then 0x22 → o_rvalid[0] with 0x11, then o_rvalid[1] with 0x22 on the following cycle; a write interleaved between them produces no o_rvalid.
- Reset mid-flight: issue a read (MEM_LATENCY = 3), assert i_rst one cycle after mem_en → no o_rvalid at any later cycle; RR pointer restarts with port 0.
